// File: rtl/ahb_wr_snoop_fifo.sv
// Passive AHB-Lite write snooper: in-window completed writes go into a first-word-fall-through FIFO.
// Define M14K_SNOOP_TIMESTAMP_EN to stamp each entry with a free-running 16-bit cycle counter.
module ahb_wr_snoop_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h1F80_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
  parameter int          DEPTH     = 8,
  parameter int          CNT_W     = 4
) (
  input  logic             HCLK,
  input  logic             SI_Reset,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [2:0]       wr_size,
  output logic [15:0]      wr_stamp,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             r_pend_vld;
  logic [31:0]      r_pend_addr;
  logic [2:0]       r_pend_size;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [31:0]      r_mem_addr [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [2:0]       r_mem_size [DEPTH];

  logic w_hit;
  logic w_qualify;
  logic w_push;
  logic w_pop;
  logic w_valid;
  logic w_full;
  logic w_accept;
  logic w_drop;
  logic w_unused_htrans0;

  assign w_unused_htrans0 = HTRANS[0];

  assign w_hit     = ((HADDR & ADDR_MASK) == BASE_ADDR);
  assign w_qualify = HREADY & HTRANS[1] & HWRITE & w_hit;
  assign w_push    = r_pend_vld & HREADY;
  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = w_valid & wr_ready;
  // A pop at the same edge frees the slot, so a push at full is still accepted.
  assign w_accept  = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_size <= '0;
    end else if (w_qualify) begin
      r_pend_vld  <= 1'b1;
      r_pend_addr <= HADDR;
      r_pend_size <= HSIZE;
    end else if (w_push) begin
      r_pend_vld  <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  // Storage needs no reset: outputs are forced to zero whenever the FIFO is empty.
  always_ff @(posedge HCLK) begin
    if (w_accept) begin
      r_mem_addr[r_wr_ptr] <= r_pend_addr;
      r_mem_data[r_wr_ptr] <= HWDATA;
      r_mem_size[r_wr_ptr] <= r_pend_size;
    end
  end

  assign wr_valid   = w_valid;
  assign wr_addr    = w_valid ? r_mem_addr[r_rd_ptr] : '0;
  assign wr_data    = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign wr_size    = w_valid ? r_mem_size[r_rd_ptr] : '0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

`ifdef M14K_SNOOP_TIMESTAMP_EN
  logic [15:0] r_ts;
  logic [15:0] r_mem_stamp [DEPTH];

  always_ff @(posedge HCLK) begin
    if (SI_Reset) r_ts <= '0;
    else          r_ts <= r_ts + 16'd1;
  end

  always_ff @(posedge HCLK) begin
    if (w_accept) r_mem_stamp[r_wr_ptr] <= r_ts;
  end

  assign wr_stamp = w_valid ? r_mem_stamp[r_rd_ptr] : '0;
`else
  assign wr_stamp = '0;
`endif

endmodule

// File: doc/ahb_wr_snoop_fifo.md
Name: ahb_wr_snoop_fifo

Overview:
- Passive AHB-Lite write monitor downstream of the m14k core's bus outputs (HADDR/HWDATA/HWRITE plus control).
- Captures every completed write that falls inside one configurable address window into a FIFO.
- A downstream consumer (LED/7-seg driver, UART TX, debug logger) drains the FIFO with a valid/ready handshake.
- Never drives the AHB bus; the existing AHB-Lite slave still responds to every transfer.

Parameters:
- BASE_ADDR, 32'h1F80_0000: window base; compared after masking.
- ADDR_MASK, 32'hFFFF_F000: window mask; hit when (HADDR & ADDR_MASK) == BASE_ADDR.
- DEPTH, 8: FIFO entries; power of two, 2..64.
- CNT_W, 4: width of fifo_count; must satisfy 2^CNT_W > DEPTH.

Ports:
- HCLK  in  1  single clock; all logic on rising edge.
- SI_Reset  in  1  synchronous reset, active-high.
- HADDR  in  32  AHB address (address phase).
- HTRANS  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ.
- HWRITE  in  1  AHB write flag (address phase).
- HSIZE  in  3  AHB size (address phase).
- HWDATA  in  32  AHB write data (data phase).
- HREADY  in  1  AHB ready from the slave; a phase completes only when HREADY=1.
- wr_valid  out  1  FIFO head entry valid.
- wr_ready  in  1  consumer accepts the head entry.
- wr_addr  out  32  captured address of the head entry.
- wr_data  out  32  captured HWDATA, raw lanes, no endian swap.
- wr_size  out  3  captured HSIZE.
- wr_stamp  out  16  cycle timestamp (see Optional Feature).
- fifo_count  out  CNT_W  occupancy, 0..DEPTH.
- overflow  out  1  sticky: set when a captured write is dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (SI_Reset=1 at an edge) sets:
  - pend_valid=0, FIFO empty, fifo_count=0.
  - wr_valid=0, wr_addr=0, wr_data=0, wr_size=0, wr_stamp=0, overflow=0.
  - Any in-flight pending write is discarded.
- Address-phase qualify:
  - A write qualifies at an edge where HREADY=1, HTRANS[1]=1, HWRITE=1 and the window hits.
  - On qualify: pend_valid<=1, pend_addr<=HADDR, pend_size<=HSIZE.
- Data phase:
  - The first edge after qualify where HREADY=1 completes it: push {pend_addr, HWDATA, pend_size}.
  - While HREADY=0: pend held unchanged; HWDATA is not sampled.
  - If pend_valid=1, HREADY=1 and no new qualify: pend_valid<=0.
- Back-to-back transfers:
  - At one HREADY=1 edge, the previous data phase pushes AND the new address phase loads pend in the same cycle.
  - No bubble is required; the bench must sustain one push per cycle.
- Non-qualifying traffic (reads, IDLE/BUSY, out-of-window) never modifies pend; pend still clears on its own data-phase completion.
- Latency: a data phase completing at edge N into an empty FIFO gives wr_valid=1 in the cycle after edge N, with the entry on wr_* (first-word-fall-through).
- Pop:
  - Occurs at an edge with wr_valid=1 and wr_ready=1.
  - wr_* advance to the next entry in the following cycle, or wr_valid falls if that was the last entry.
  - wr_ready while wr_valid=0 is ignored.
- FIFO storage:
  - Circular buffer with rd/wr pointers modulo DEPTH; wrap-around is seamless.
  - fifo_count updates as +1 (push only), -1 (pop only), or unchanged (both or neither).
- Full:
  - Push with fifo_count==DEPTH and no pop: entry dropped, overflow<=1, count unchanged.
  - Push and pop at the same edge while full: push accepted, count stays DEPTH, no overflow.
- Empty: push and no pop at the same edge leaves count=1; no bypass, output is registered.
- overflow:
  - Cleared by overflow_clr=1.
  - Set and clear in the same cycle: set wins.
  - Only reset or overflow_clr clears it.

Optional Feature:
- Macro: M14K_SNOOP_TIMESTAMP_EN.
- Defined:
  - 16-bit free-running counter, reset 0, wraps 16'hFFFF->0.
  - Its value at the data-phase completion edge is stored with each entry and presented on wr_stamp.
- Undefined: no counter and no stamp storage; wr_stamp is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Single write HADDR=0x1F800004, HWDATA=0x12345678, HSIZE=2, HREADY=1 -> next cycle wr_valid=1, wr_addr=0x1F800004, wr_data=0x12345678, wr_size=2, fifo_count=1; after wr_ready pop, count=0.
- Write to 0x1F801000 (out of window), a read at 0x1F800000, and an IDLE transfer -> no push; wr_valid stays 0.
- Write to 0x1F800008 with HREADY=0 for 3 data-phase cycles, HWDATA changing each cycle -> exactly one entry, carrying HWDATA sampled on the HREADY=1 edge.
- 10 back-to-back writes with wr_ready=0, DEPTH=8 -> count=8, overflow=1, entries 1-8 retained in order; overflow_clr pulse clears it; a later write with wr_ready=1 at full is accepted with no overflow.
- Reset asserted between address phase and data phase -> no entry, all outputs 0; the next write is captured normally.
- With M14K_SNOOP_TIMESTAMP_EN: writes completing at counter values 5 and 9 -> wr_stamp 5 then 9; across a counter wrap, the stamp reads 0x0000 after 0xFFFF.
